// File: rtl/conv_layer_sequencer_if.sv
// Handshake and configuration bundle between the layer controller,
// the kernel sequencer and the ConvL2 datapath.
interface conv_layer_sequencer_if #(
  parameter int KW         = 3,
  parameter int ADDR_WIDTH = 10
);
  logic                  start;
  logic                  abort;
  logic                  conv_done;
  logic                  conv_run;
  logic [KW-1:0]         kernel_idx;
  logic [ADDR_WIDTH-1:0] weight_base_out;
  logic [ADDR_WIDTH-1:0] result_base_out;
  logic                  busy;
  logic                  layer_done;
  logic                  error;

  // Controller / datapath side.
  modport master (
    output start, abort, conv_done,
    input  conv_run, kernel_idx, weight_base_out, result_base_out,
           busy, layer_done, error
  );

  // Sequencer side.
  modport slave (
    input  start, abort, conv_done,
    output conv_run, kernel_idx, weight_base_out, result_base_out,
           busy, layer_done, error
  );
endinterface

// File: rtl/conv_layer_sequencer.sv
// Runs one ConvL2 layer kernel by kernel: configure, settle, pulse run,
// wait for done, with a watchdog that parks the sequencer in ERROR.
module conv_layer_sequencer #(
  parameter int NUM_KERNELS    = 6,
  parameter int ADDR_WIDTH     = 10,
  parameter int WEIGHT_STRIDE  = 9,
  parameter int RESULT_STRIDE  = 100,
  parameter int SETTLE_CYCLES  = 2,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input logic                   clk,
  input logic                   reset,
  conv_layer_sequencer_if.slave bus
);

  localparam int KW = (NUM_KERNELS > 1) ? $clog2(NUM_KERNELS) : 1;
  localparam int SW = $clog2(SETTLE_CYCLES + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES);

  localparam logic [KW-1:0] LAST_K     = KW'(NUM_KERNELS - 1);
  localparam logic [SW-1:0] SETTLE_END = SW'(SETTLE_CYCLES);
  localparam logic [TW-1:0] WD_END     = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_RUN,
    S_WAIT,
    S_NEXT,
    S_DONE,
    S_ERROR
  } state_t;

  state_t                state;
  logic [KW-1:0]         kidx;
  logic [ADDR_WIDTH-1:0] wbase;
  logic [ADDR_WIDTH-1:0] rbase;
  logic                  run_q;
  logic                  ld_q;
  logic                  busy_q;
  logic                  err_q;
  logic [SW-1:0]         settle_cnt;
  logic [TW-1:0]         wd_cnt;

  function automatic logic [ADDR_WIDTH-1:0] base_of(input logic [KW-1:0] k,
                                                    input logic [31:0]   stride);
    return ADDR_WIDTH'(32'(k) * stride);
  endfunction

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= S_IDLE;
      kidx       <= '0;
      wbase      <= '0;
      rbase      <= '0;
      run_q      <= 1'b0;
      ld_q       <= 1'b0;
      busy_q     <= 1'b0;
      err_q      <= 1'b0;
      settle_cnt <= '0;
      wd_cnt     <= '0;
    end else begin
      run_q <= 1'b0;
      ld_q  <= 1'b0;
      if (bus.abort) begin
        // Abort wins over every other request, including a pending done.
        state      <= S_IDLE;
        kidx       <= '0;
        wbase      <= '0;
        rbase      <= '0;
        busy_q     <= 1'b0;
        err_q      <= 1'b0;
        settle_cnt <= '0;
      end else begin
        case (state)
          S_IDLE, S_ERROR: begin
            if (bus.start) begin
              state      <= S_SETUP;
              kidx       <= '0;
              wbase      <= '0;
              rbase      <= '0;
              busy_q     <= 1'b1;
              err_q      <= 1'b0;
              settle_cnt <= '0;
            end
          end
          S_SETUP: begin
            // One entry cycle plus SETTLE_CYCLES so the M10K read pipe sees the new bases.
            if (settle_cnt == SETTLE_END) begin
              state      <= S_RUN;
              run_q      <= 1'b1;
              settle_cnt <= '0;
            end else begin
              settle_cnt <= settle_cnt + SW'(1);
            end
          end
          S_RUN: begin
            state  <= S_WAIT;
            wd_cnt <= '0;
          end
          S_WAIT: begin
            if (bus.conv_done) begin
              state <= S_NEXT;
            end else if (wd_cnt == WD_END) begin
              state  <= S_ERROR;
              busy_q <= 1'b0;
              err_q  <= 1'b1;
            end else begin
              wd_cnt <= wd_cnt + TW'(1);
            end
          end
          S_NEXT: begin
            if (kidx == LAST_K) begin
              state <= S_DONE;
              ld_q  <= 1'b1;
            end else begin
              state      <= S_SETUP;
              kidx       <= kidx + KW'(1);
              wbase      <= base_of(kidx + KW'(1), 32'(WEIGHT_STRIDE));
              rbase      <= base_of(kidx + KW'(1), 32'(RESULT_STRIDE));
              settle_cnt <= '0;
            end
          end
          S_DONE: begin
            state  <= S_IDLE;
            busy_q <= 1'b0;
          end
          default: begin
            state  <= S_IDLE;
            busy_q <= 1'b0;
          end
        endcase
      end
    end
  end

  assign bus.conv_run        = run_q;
  assign bus.kernel_idx      = kidx;
  assign bus.weight_base_out = wbase;
  assign bus.result_base_out = rbase;
  assign bus.busy            = busy_q;
  assign bus.layer_done      = ld_q;
  assign bus.error           = err_q;

endmodule
